// File: rtl/sd_spi_engine_if.sv
// Host-side handshake for sd_spi_engine: transfer request, options and result.
interface sd_spi_engine_if;
    logic       start;
    logic       init_clks;
    logic       slow;
    logic       cs_hold;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       busy;
    logic       done;

    modport master (
        output start, init_clks, slow, cs_hold, tx_byte,
        input  rx_byte, busy, done
    );

    modport slave (
        input  start, init_clks, slow, cs_hold, tx_byte,
        output rx_byte, busy, done
    );
endinterface

// File: rtl/sd_spi_engine.sv
// SPI mode-0 byte engine for SD cards, with an 80-clock init sequence and
// selectable slow/fast sclk divider.
module sd_spi_engine #(
    parameter int unsigned SLOW_DIV = 124,
    parameter int unsigned FAST_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    sd_spi_engine_if.slave  host,
    input  logic            miso,
    output logic            sclk,
    output logic            mosi,
    output logic            cs_n
);

    typedef enum logic [1:0] {StIdle, StInit, StXfer, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  half_q, half_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_q, rx_d;
    logic        slow_q, slow_d;
    logic        hold_q, hold_d;

    logic [15:0] div_lim;
    logic [7:0]  half_last;
    logic        tick;

    assign div_lim   = (state_q == StInit || slow_q) ? 16'(SLOW_DIV) : 16'(FAST_DIV);
    assign half_last = (state_q == StInit) ? 8'd160 : 8'd16;
    assign tick      = (cnt_q >= div_lim);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        slow_d  = slow_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    tx_d   = host.tx_byte;
                    slow_d = host.slow;
                    hold_d = host.cs_hold;
                    // The start cycle itself counts as the first divider tick.
                    cnt_d  = 16'd1;
                    half_d = 8'd0;
                    sclk_d = 1'b0;
                    if (host.init_clks) begin
                        state_d = StInit;
                        cs_d    = 1'b1;
                    end else begin
                        state_d = StXfer;
                        cs_d    = 1'b0;
                    end
                end
            end
            StInit, StXfer: begin
                if (half_q == half_last) begin
                    state_d = StDone;
                    cnt_d   = 16'd0;
                    if (state_q == StXfer) begin
                        rx_d = rx_sh_q;
                        if (!hold_q) cs_d = 1'b1;
                    end
                end else if (tick) begin
                    cnt_d  = 16'd0;
                    sclk_d = ~sclk_q;
                    half_d = half_q + 8'd1;
                    if (state_q == StXfer) begin
                        if (!sclk_q) rx_sh_d = {rx_sh_q[6:0], miso};
                        else         tx_d    = {tx_q[6:0], 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            half_q  <= 8'd0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            tx_q    <= 8'h00;
            rx_sh_q <= 8'h00;
            rx_q    <= 8'h00;
            slow_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            slow_q  <= slow_d;
            hold_q  <= hold_d;
        end
    end

    assign host.busy    = (state_q != StIdle);
    assign host.done    = (state_q == StDone);
    assign host.rx_byte = rx_q;
    assign sclk         = sclk_q;
    assign cs_n         = cs_q;
    assign mosi         = (state_q == StXfer) ? tx_q[7] : 1'b1;

endmodule
